// File: rtl/modport_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : modport_mem_if
// Brief    : Processor-side memory bus. The driver issues read/write requests
//            and the memory returns registered read data with a valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
interface modport_mem_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
);
  logic                  write_en;
  logic                  read_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;

  // Request side (processor / driver)
  modport master (
    output write_en, read_en, addr, data_in,
    input  data_out, valid_out
  );

  // Storage side (memory endpoint)
  modport slave (
    input  write_en, read_en, addr, data_in,
    output data_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/modport_mem.sv
`default_nettype none
// ============================================================================
// Module   : modport_mem
// Brief    : Single-port synchronous byte memory (2^ADDR_WIDTH x DATA_WIDTH)
//            with a registered read port, read-before-write on address
//            collision and a one-cycle valid strobe per accepted read.
//            reset_n is active-high and synchronous despite its name.
//            Optional macro MODPORT_MEM_CLEAR_EN: when defined, every reset
//            edge also zeroes the whole array.
// Revision : 1.0 - initial release
// ============================================================================
module modport_mem #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  wire          clk,
  input  wire          reset_n,
  modport_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;

  // Storage array: writes are dropped while reset is asserted
  always_ff @(posedge clk) begin
    if (reset_n) begin
`ifdef MODPORT_MEM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
`endif
    end else if (bus.write_en) begin
      mem_q[bus.addr] <= bus.data_in;
    end
  end

  // Read-path next state: the array is read before this edge's write lands,
  // which gives read-before-write on a same-address collision
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = bus.read_en;
    if (bus.read_en) begin
      data_out_d = mem_q[bus.addr];
    end
  end

  // Read-path registers: data holds between reads, valid is a strobe
  always_ff @(posedge clk) begin
    if (reset_n) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_modport_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_modport_mem
// Brief    : Directed self-checking bench for modport_mem.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modport_mem;

  localparam int ADDR_WIDTH = 11;
  localparam int DATA_WIDTH = 8;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  modport_mem_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

  modport_mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic [10:0] a, input logic [7:0] d);
    bus.write_en = we;
    bus.read_en  = re;
    bus.addr     = a;
    bus.data_in  = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // Reset held two cycles with requests present
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 11'h005, 8'h77);
    tick();
    check("rst1_valid", {31'd0, bus.valid_out}, 32'd0);
    check("rst1_data", {24'd0, bus.data_out}, 32'h00);
    tick();
    check("rst2_valid", {31'd0, bus.valid_out}, 32'd0);
    check("rst2_data", {24'd0, bus.data_out}, 32'h00);
    reset_n = 1'b0;

`ifdef MODPORT_MEM_CLEAR_EN
    drive(1'b0, 1'b1, 11'h005, 8'h00);
    tick();
    check("clr_valid", {31'd0, bus.valid_out}, 32'd1);
    check("clr_data", {24'd0, bus.data_out}, 32'h00);
`endif

    // Write then read
    drive(1'b1, 1'b0, 11'h123, 8'hA5);
    tick();
    check("wr_only_valid", {31'd0, bus.valid_out}, 32'd0);
    drive(1'b0, 1'b1, 11'h123, 8'h00);
    tick();
    check("rd_valid", {31'd0, bus.valid_out}, 32'd1);
    check("rd_data", {24'd0, bus.data_out}, 32'hA5);
    drive(1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    check("idle_valid", {31'd0, bus.valid_out}, 32'd0);
    check("idle_hold", {24'd0, bus.data_out}, 32'hA5);

    // Address boundaries, read back-to-back
    drive(1'b1, 1'b0, 11'h000, 8'h11);
    tick();
    drive(1'b1, 1'b0, 11'h7FF, 8'hEE);
    tick();
    drive(1'b0, 1'b1, 11'h000, 8'h00);
    tick();
    check("lo_valid", {31'd0, bus.valid_out}, 32'd1);
    check("lo_data", {24'd0, bus.data_out}, 32'h11);
    drive(1'b0, 1'b1, 11'h7FF, 8'h00);
    tick();
    check("hi_valid", {31'd0, bus.valid_out}, 32'd1);
    check("hi_data", {24'd0, bus.data_out}, 32'hEE);
    drive(1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    check("bnd_end_valid", {31'd0, bus.valid_out}, 32'd0);

    // Read during write to the same address
    drive(1'b1, 1'b0, 11'h040, 8'h3C);
    tick();
    drive(1'b1, 1'b1, 11'h040, 8'hC3);
    tick();
    check("rdw_valid", {31'd0, bus.valid_out}, 32'd1);
    check("rdw_old", {24'd0, bus.data_out}, 32'h3C);
    drive(1'b0, 1'b1, 11'h040, 8'h00);
    tick();
    check("rdw_new", {24'd0, bus.data_out}, 32'hC3);

    // Streaming 16 writes then 16 reads
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 11'h200 + 11'(i), 8'(i));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 11'h200 + 11'(i), 8'h00);
      tick();
      check($sformatf("strm_valid%0d", i), {31'd0, bus.valid_out}, 32'd1);
      check($sformatf("strm_data%0d", i), {24'd0, bus.data_out}, 32'(i));
    end
    drive(1'b0, 1'b0, 11'h000, 8'h00);
    tick();
    check("strm_end_valid", {31'd0, bus.valid_out}, 32'd0);

    // Reset mid-read; write during reset is discarded
    drive(1'b1, 1'b0, 11'h050, 8'h5A);
    tick();
    drive(1'b0, 1'b1, 11'h050, 8'h00);
    tick();
    check("mid_pre_valid", {31'd0, bus.valid_out}, 32'd1);
    check("mid_pre_data", {24'd0, bus.data_out}, 32'h5A);
    reset_n = 1'b1;
    drive(1'b1, 1'b1, 11'h050, 8'hFF);
    tick();
    check("mid_rst_valid", {31'd0, bus.valid_out}, 32'd0);
    check("mid_rst_data", {24'd0, bus.data_out}, 32'h00);
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 11'h050, 8'h00);
    tick();
    check("mid_post_valid", {31'd0, bus.valid_out}, 32'd1);
`ifdef MODPORT_MEM_CLEAR_EN
    check("mid_post_data", {24'd0, bus.data_out}, 32'h00);
`else
    check("mid_post_data", {24'd0, bus.data_out}, 32'h5A);
`endif
    drive(1'b0, 1'b0, 11'h000, 8'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
